// File: rtl/bconv_pkg.sv
// ============================================================================
// bconv_pkg : shared types and sizing helpers for the binary conv sequencer
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package bconv_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        VS     = 4'd1,
        HS     = 4'd2,
        WLOAD  = 4'd3,
        WDRAIN = 4'd4,
        WAIT   = 4'd5,
        REUSE  = 4'd6,
        GAP    = 4'd7,
        STREAM = 4'd8,
        DONE   = 4'd9
    } sched_st_t;

    localparam int c_LANES = 16;

    function automatic int wbeats(input int channel, input int lanes);
        return channel / lanes;
    endfunction

    // Bits needed to hold every value 0..terminal (never narrower than 1).
    function automatic int cnt_w(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bconv_wfetch.sv
// ============================================================================
// bconv_wfetch : weight beat fetcher - read strobes, addresses, beat strobes
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module bconv_wfetch
    import bconv_pkg::*;
#(
    parameter int WIDTH_W = 18,
    parameter int LANES   = 16,
    parameter int WBEATS  = 16,
    parameter int ADDR_W  = 12
) (
    input  logic                       i_sclk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_restart,
    output logic                       o_last,
    output logic                       o_wmem_rd,
    output logic [ADDR_W-1:0]          o_wmem_addr,
    input  logic [WIDTH_W*LANES-1:0]   i_wmem_data,
    output logic                       o_weight_vld,
    output logic [WIDTH_W*LANES-1:0]   o_weight
);

    localparam int                  c_BEAT_W    = cnt_w(WBEATS - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(WBEATS - 1);

    logic [c_BEAT_W-1:0] r_beat;
    logic                r_rd;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_weight_vld;

    assign o_last       = r_rd && (r_beat == c_BEAT_LAST);
    assign o_wmem_rd    = r_rd;
    assign o_wmem_addr  = r_addr;
    assign o_weight_vld = r_weight_vld;
    // Memory data is already registered at the BRAM; gate it so idle cycles read as zero.
    assign o_weight     = r_weight_vld ? i_wmem_data : '0;

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat       <= '0;
            r_rd         <= 1'b0;
            r_addr       <= '0;
            r_weight_vld <= 1'b0;
        end else begin
            r_weight_vld <= r_rd;
            if (i_start) begin
                // Passes are contiguous in memory, so the next pass starts one past the last beat.
                r_rd   <= 1'b1;
                r_beat <= '0;
                r_addr <= i_restart ? '0 : r_addr + ADDR_W'(1);
            end else if (r_rd) begin
                if (o_last) begin
                    r_rd <= 1'b0;
                end else begin
                    r_beat <= r_beat + c_BEAT_W'(1);
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bconv_pass_sched.sv
// ============================================================================
// bconv_pass_sched : frame/row/pass sequencer feeding the binary 3x3 conv engine
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module bconv_pass_sched
    import bconv_pkg::*;
#(
    parameter int WIDTH_W   = 18,
    parameter int LANES     = c_LANES,
    parameter int CHANNEL   = 256,
    parameter int PASSES    = CHANNEL / 2,
    parameter int SIZE      = 56,
    parameter int ROWS      = 56,
    parameter int REUSE_GAP = 4,
    parameter int ADDR_W    = $clog2(PASSES * wbeats(CHANNEL, LANES))
) (
    input  logic                       i_sclk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_wmem_rd,
    output logic [ADDR_W-1:0]          o_wmem_addr,
    input  logic [WIDTH_W*LANES-1:0]   i_wmem_data,
    input  logic                       i_eng_ready,
    input  logic                       i_pix_valid,
    output logic                       o_pix_ready,
    input  logic [WIDTH_W-1:0]         i_pix_data,
    output logic                       o_vsync,
    output logic                       o_hsync,
    output logic                       o_reuse,
    output logic                       o_weight_vld,
    output logic [WIDTH_W*LANES-1:0]   o_weight,
    output logic                       o_valid,
    output logic [WIDTH_W-1:0]         o_tdata
);

    localparam int c_WBEATS = wbeats(CHANNEL, LANES);
    localparam int c_PASS_W = cnt_w(PASSES - 1);
    localparam int c_ROW_W  = cnt_w(ROWS - 1);
    localparam int c_PIX_W  = cnt_w(SIZE - 1);
    localparam int c_GAP_W  = cnt_w(REUSE_GAP - 1);

    localparam logic [c_PASS_W-1:0] c_PASS_LAST = c_PASS_W'(PASSES - 1);
    localparam logic [c_ROW_W-1:0]  c_ROW_LAST  = c_ROW_W'(ROWS - 1);
    localparam logic [c_PIX_W-1:0]  c_PIX_LAST  = c_PIX_W'(SIZE - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(REUSE_GAP - 1);

    sched_st_t           r_state;
    logic [c_PASS_W-1:0] r_pass;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_PIX_W-1:0]  r_pix;
    logic [c_GAP_W-1:0]  r_gap;
    logic                r_busy;
    logic                r_done;
    logic                r_vsync;
    logic                r_hsync;
    logic                r_reuse;
    logic                r_pix_ready;
    logic                r_valid;
    logic [WIDTH_W-1:0]  r_tdata;

    logic w_accept;
    logic w_pix_last;
    logic w_fetch_start;
    logic w_fetch_restart;
    logic w_fetch_last;

    assign w_accept        = (r_state == STREAM) && r_pix_ready && i_pix_valid;
    assign w_pix_last      = (r_pix == c_PIX_LAST);
    assign w_fetch_restart = (r_state == HS);
    // Fetch kicks off on the same edge the FSM enters WLOAD, so rd lines up with that state.
    assign w_fetch_start   = w_fetch_restart || (w_accept && w_pix_last && (r_pass != c_PASS_LAST));

    bconv_wfetch #(
        .WIDTH_W (WIDTH_W),
        .LANES   (LANES),
        .WBEATS  (c_WBEATS),
        .ADDR_W  (ADDR_W)
    ) u_wfetch (
        .i_sclk       (i_sclk),
        .i_rst_n      (i_rst_n),
        .i_start      (w_fetch_start),
        .i_restart    (w_fetch_restart),
        .o_last       (w_fetch_last),
        .o_wmem_rd    (o_wmem_rd),
        .o_wmem_addr  (o_wmem_addr),
        .i_wmem_data  (i_wmem_data),
        .o_weight_vld (o_weight_vld),
        .o_weight     (o_weight)
    );

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_pass      <= '0;
            r_row       <= '0;
            r_pix       <= '0;
            r_gap       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_vsync     <= 1'b0;
            r_hsync     <= 1'b0;
            r_reuse     <= 1'b0;
            r_pix_ready <= 1'b0;
            r_valid     <= 1'b0;
            r_tdata     <= '0;
        end else begin
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_reuse <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= VS;
                        r_vsync <= 1'b1;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                    end
                end
                VS: begin
                    r_state <= HS;
                    r_hsync <= 1'b1;
                    r_pass  <= '0;
                end
                HS:     r_state <= WLOAD;
                WLOAD:  if (w_fetch_last) r_state <= WDRAIN;
                WDRAIN: r_state <= WAIT;
                WAIT: begin
                    if (i_eng_ready) begin
                        r_state <= REUSE;
                        r_reuse <= 1'b1;
                    end
                end
                REUSE: begin
                    r_state <= GAP;
                    r_gap   <= '0;
                end
                GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state     <= STREAM;
                        r_pix_ready <= 1'b1;
                        r_pix       <= '0;
                    end else begin
                        r_gap <= r_gap + c_GAP_W'(1);
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        r_valid <= 1'b1;
                        r_tdata <= i_pix_data;
                        if (w_pix_last) begin
                            r_pix_ready <= 1'b0;
                            r_pix       <= '0;
                            if (r_pass != c_PASS_LAST) begin
                                r_pass  <= r_pass + c_PASS_W'(1);
                                r_state <= WLOAD;
                            end else if (r_row != c_ROW_LAST) begin
                                r_row   <= r_row + c_ROW_W'(1);
                                r_pass  <= '0;
                                r_hsync <= 1'b1;
                                r_state <= HS;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end
                        end else begin
                            r_pix <= r_pix + c_PIX_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_vsync     = r_vsync;
    assign o_hsync     = r_hsync;
    assign o_reuse     = r_reuse;
    assign o_pix_ready = r_pix_ready;
    assign o_valid     = r_valid;
    assign o_tdata     = r_tdata;

endmodule

`default_nettype wire

// File: tb/tb_bconv_pass_sched.sv
// ============================================================================
// tb_bconv_pass_sched : scoreboard bench for the conv pass sequencer
// Rev 1.0             : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bconv_pass_sched;

    localparam int WIDTH_W   = 18;
    localparam int LANES     = 16;
    localparam int CHANNEL   = 32;
    localparam int PASSES    = 16;
    localparam int SIZE      = 4;
    localparam int ROWS      = 2;
    localparam int REUSE_GAP = 4;
    localparam int WBEATS    = CHANNEL / LANES;
    localparam int ADDR_W    = $clog2(PASSES * WBEATS);
    localparam int WD        = WIDTH_W * LANES;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               busy, done, wmem_rd, eng_ready, pix_valid, pix_ready;
    logic               vsync, hsync, reuse, weight_vld, valid;
    logic [ADDR_W-1:0]  wmem_addr;
    logic [WD-1:0]      wmem_data, weight;
    logic [WIDTH_W-1:0] pix_data, tdata;

    bconv_pass_sched #(
        .WIDTH_W(WIDTH_W), .LANES(LANES), .CHANNEL(CHANNEL), .PASSES(PASSES),
        .SIZE(SIZE), .ROWS(ROWS), .REUSE_GAP(REUSE_GAP), .ADDR_W(ADDR_W)
    ) dut (
        .i_sclk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
        .o_wmem_rd(wmem_rd), .o_wmem_addr(wmem_addr), .i_wmem_data(wmem_data),
        .i_eng_ready(eng_ready), .i_pix_valid(pix_valid), .o_pix_ready(pix_ready),
        .i_pix_data(pix_data), .o_vsync(vsync), .o_hsync(hsync), .o_reuse(reuse),
        .o_weight_vld(weight_vld), .o_weight(weight), .o_valid(valid), .o_tdata(tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0]  q_a[$];
    logic [WD-1:0]      q_w[$];
    logic [WIDTH_W-1:0] q_p[$];

    int cyc = 0, last_wv = -100, last_reuse = -100;
    int vs_total = 0, vs_base = 0, hs_total = 0, hs_seen = 0;
    int hs_cnt = 0, reuse_cnt = 0, wv_cnt = 0, val_cnt = 0, done_cnt = 0;
    int hs_pass = 0, pass_beats = 0;
    logic prev_ready = 1'b1;
    logic mem_req = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic stall = 1'b0;

    task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model and pixel source: data returned one cycle after each read.
    always @(posedge clk) begin
        #1;
        wmem_data = mem_req ? WD'(mem_addr) : '0;
        if (hs_total != hs_seen) begin
            hs_seen  = hs_total;
            pix_data = WIDTH_W'($urandom);
        end
        pix_valid = stall ? ~pix_valid : 1'b1;
    end

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (vsync) begin
                vs_total++;
                hs_cnt = 0; reuse_cnt = 0; wv_cnt = 0; val_cnt = 0; done_cnt = 0;
                hs_pass = 0; pass_beats = 0;
            end
            if (hsync) hs_cnt++;
            if (wmem_rd) begin
                chk("rd_after_hsync", WD'(hs_cnt > 0), WD'(1));
                chk("addr_q_nonempty", WD'(q_a.size() != 0), WD'(1));
                if (q_a.size() != 0) chk("wmem_addr", WD'(wmem_addr), WD'(q_a.pop_front()));
            end
            if (weight_vld) begin
                chk("weight_q_nonempty", WD'(q_w.size() != 0), WD'(1));
                if (q_w.size() != 0) chk("weight", weight, q_w.pop_front());
                last_wv = cyc; pass_beats++; wv_cnt++;
            end
            if (reuse) begin
                chk("reuse_ready", WD'(prev_ready), WD'(1));
                chk("reuse_beats", WD'(pass_beats), WD'(WBEATS));
                chk("reuse_latency", WD'(cyc - last_wv >= 2), WD'(1));
                if (reuse_cnt > 0) chk("pix_per_pass", WD'(hs_pass), WD'(SIZE));
                hs_pass = 0; pass_beats = 0; reuse_cnt++; last_reuse = cyc;
            end
            if (valid) begin
                chk("reuse_gap", WD'(cyc - last_reuse >= REUSE_GAP), WD'(1));
                chk("pix_q_nonempty", WD'(q_p.size() != 0), WD'(1));
                if (q_p.size() != 0) chk("tdata", WD'(tdata), WD'(q_p.pop_front()));
                val_cnt++;
            end
            if (done) begin
                chk("last_pass_pix", WD'(hs_pass), WD'(SIZE));
                done_cnt++;
            end
            if (pix_valid && pix_ready) begin
                q_p.push_back(pix_data);
                hs_pass++; hs_total++;
            end
            mem_req    = wmem_rd;
            mem_addr   = wmem_addr;
            prev_ready = eng_ready;
        end else begin
            mem_req = 1'b0;
        end
    end

    function automatic int cur(input int sel);
        case (sel)
            0: return reuse_cnt;
            1: return done_cnt;
            default: return hs_cnt;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int n, input string tag);
        for (int i = 0; i < 4000; i++) begin
            if (cur(sel) >= n) break;
            @(negedge clk); #1;
        end
        chk(tag, WD'(cur(sel) >= n), WD'(1));
    endtask

    task automatic push_frame();
        q_a.delete(); q_w.delete(); q_p.delete();
        for (int r = 0; r < ROWS; r++)
            for (int a = 0; a < PASSES * WBEATS; a++) begin
                q_a.push_back(ADDR_W'(a));
                q_w.push_back(WD'(a));
            end
    endtask

    task automatic begin_frame();
        vs_base = vs_total;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 20 && vs_total == vs_base; i++) begin
            @(negedge clk); #1;
        end
        chk("frame_start", WD'(vs_total - vs_base), WD'(1));
    endtask

    task automatic check_totals();
        chk("vsync_total", WD'(vs_total - vs_base), WD'(1));
        chk("hsync_total", WD'(hs_cnt), WD'(ROWS));
        chk("reuse_total", WD'(reuse_cnt), WD'(ROWS * PASSES));
        chk("wbeat_total", WD'(wv_cnt), WD'(ROWS * PASSES * WBEATS));
        chk("valid_total", WD'(val_cnt), WD'(ROWS * PASSES * SIZE));
        chk("done_total", WD'(done_cnt), WD'(1));
        chk("queues_empty", WD'(q_a.size() + q_w.size() + q_p.size()), WD'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; eng_ready = 1'b1;
        pix_valid = 1'b0; pix_data = '0; wmem_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", WD'({busy, done, wmem_rd, vsync, hsync, reuse, weight_vld,
                                  valid, pix_ready, wmem_addr, tdata}), WD'(0));
        chk("reset_weight", weight, WD'(0));
        rst_n = 1'b1;

        // Nominal frame with a stray start mid-frame.
        push_frame();
        begin_frame();
        wait_for(0, 5, "wait_reuse5");
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_for(1, 1, "wait_done_f1");
        check_totals();
        @(negedge clk); #1;
        chk("busy_after_done", WD'(busy), WD'(0));

        // Engine backpressure at pass 3, start held through DONE.
        push_frame();
        begin_frame();
        wait_for(0, 3, "wait_reuse3");
        eng_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_reuse_held", WD'(reuse_cnt), WD'(3));
        eng_ready = 1'b1;
        wait_for(0, ROWS * PASSES, "wait_last_pass");
        start = 1'b1;
        wait_for(1, 1, "wait_done_f2");
        @(posedge clk); #1 start = 1'b0;
        check_totals();
        repeat (5) @(posedge clk);
        #1;
        chk("start_at_done_busy", WD'(busy), WD'(0));
        chk("start_at_done_vsync", WD'(vs_total - vs_base), WD'(1));

        // Upstream stall: pixel valid alternates.
        stall = 1'b1;
        push_frame();
        begin_frame();
        wait_for(1, 1, "wait_done_f3");
        check_totals();
        stall = 1'b0;

        // Asynchronous reset during row 1 streaming.
        push_frame();
        begin_frame();
        wait_for(2, 2, "wait_row1");
        wait_for(0, PASSES + 2, "wait_row1_pass2");
        for (int i = 0; i < 100 && !pix_ready; i++) begin
            @(negedge clk); #1;
        end
        chk("pre_reset_stream", WD'(pix_ready), WD'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", WD'({busy, done, wmem_rd, vsync, hsync, reuse, weight_vld,
                                      valid, pix_ready, wmem_addr, tdata}), WD'(0));
        chk("async_rst_weight", weight, WD'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_on_abort", WD'(done_cnt + done), WD'(0));
        rst_n = 1'b1;

        // Clean frame after abort, addresses restart at 0.
        push_frame();
        begin_frame();
        wait_for(1, 1, "wait_done_f5");
        check_totals();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
